rx_serial_8n1: RTL and testbench
================================

# rx_serial_8n1

Asynchronous serial receiver (8 data bits, no parity, 1 stop bit, LSB first) that sits directly upstream of the game control unit's reception path. It samples the incoming line, reassembles each byte and hands it over with a one-cycle `pronto_recepcao` pulse. The control unit counts these pulses and loads the three command registers from `dado_recebido`. A framing-error pulse flags bad frames, which are not handed over.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per bit (50 MHz / 9600 baud). Must be even and ≥ 4.
- `clock` in 1: single system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset; forces all state and outputs to reset values.
- `zera` in 1: synchronous clear (driven by the control unit's `zera_recpcao`).
- `rx` in 1: serial line, idle high, asynchronous to `clock`.
- `dado_recebido` out 8: last correctly framed byte.
- `pronto_recepcao` out 1: one-cycle pulse when `dado_recebido` has been updated.
- `erro_quadro` out 1: one-cycle pulse when the stop bit is sampled low.
- `db_estado` out 4: current state code, for debug.

## Operation
- `rx` passes through a 2-flop synchroniser (both flops reset to 1) to give `rx_s`. All decisions use `rx_s`.
- Bit-time counter width is clog2(`CLKS_PER_BIT`). It is cleared on every state change.
- States and `db_estado` codes:
  - `ocioso` (0000): wait for `rx_s` = 0, then go to `inicio`.
  - `inicio` (0001): after `CLKS_PER_BIT`/2 cycles, sample `rx_s`.
    - If 1: glitch; return to `ocioso` with no output.
    - If 0: go to `dados` with the bit index set to 0.
  - `dados` (0010): every `CLKS_PER_BIT` cycles, shift `rx_s` into bit position index (LSB first) and increment the index. After bit 7 is sampled, go to `parada`.
  - `parada` (0011): after `CLKS_PER_BIT` cycles, sample `rx_s`.
    - If 1: go to `entrega`.
    - If 0: pulse `erro_quadro`, leave `dado_recebido` unchanged, go to `espera_alto`.
  - `entrega` (0100): copy the shift register to `dado_recebido`, pulse `pronto_recepcao`, return to `ocioso`.
  - `espera_alto` (0101): wait for `rx_s` = 1, then go to `ocioso`. This stops a break or stuck-low line from being read as a new start bit.
  - Any unused code: go to `ocioso` next cycle; `db_estado` = 1111.
- `zera` = 1 in any state:
  - Next state is `ocioso`, the counter and bit index clear, and `dado_recebido` is set to 0x00.
  - Any frame in progress is dropped, and no pulse is produced that cycle.
  - `zera` overrides every same-cycle event, including the stop-bit sample.
- Reset (`reset` = 0), including mid-frame:
  - State goes to `ocioso` immediately.
  - `dado_recebido` = 0x00, `pronto_recepcao` = 0, `erro_quadro` = 0, `db_estado` = 0000, synchroniser flops = 1.
  - After release, a frame that was cut off mid-way is resynchronised through `ocioso` or `espera_alto` rules; no spurious pulse is produced.
- `pronto_recepcao` and `erro_quadro` are never high in the same cycle and are never high for two consecutive cycles.

## Timing
- Take cycle 0 as the first rising edge at which `rx` is sampled low at the synchroniser input.
  - `rx_s` is low at cycle 2, and the state is `inicio` from cycle 3.
  - Start bit is sampled `CLKS_PER_BIT`/2 cycles later.
  - Data bit k is sampled at start-sample + (k+1)·`CLKS_PER_BIT`; stop bit at start-sample + 9·`CLKS_PER_BIT`.
  - `pronto_recepcao` (or `erro_quadro`) is high for exactly one cycle, the cycle after the stop sample.
  - `dado_recebido` is valid in that same cycle and holds until the next good frame, `zera` or reset.
- Back-to-back frames: a new start edge is accepted from the first cycle the state is `ocioso` again. A start bit that directly follows the stop bit is received correctly.
- Accepted baud mismatch: ±2 % with no errors.

## Test plan
- Test bench uses `CLKS_PER_BIT` = 16.
- Single good frame: send byte 0xA5 → `pronto_recepcao` pulses once, `dado_recebido` = 0xA5, `erro_quadro` stays 0, state sequence 0000 → 0001 → 0010 → 0011 → 0100 → 0000.
- Back-to-back frames: send 0x01, 0x80, 0xFF with no idle gap → three `pronto_recepcao` pulses, with `dado_recebido` reading 0x01, 0x80, 0xFF in order.
- Start glitch: drive `rx` low for 4 cycles, then high → no pulse, returns to 0000, `dado_recebido` unchanged.
- Framing error: send 0x3C with the stop bit low, then hold `rx` low for 40 cycles, then high, then send 0x5A:
  - `erro_quadro` pulses once, `dado_recebido` keeps its old value, and the state stays at 0101 while `rx` is low.
  - Only 0x5A is then delivered, with one `pronto_recepcao` pulse.
- Mid-frame reset and zera:
  - Pulse `reset` low during bit 4 of 0xC3 → outputs return to reset values, no pulse for that frame, and the next 0x66 is received correctly.
  - Repeat with `zera` asserted in the stop-bit sample cycle → no pulse, `dado_recebido` = 0x00.

Source files
------------

// File: rtl/rx_serial_8n1.sv
// ---------------------------------------------------------------------------
// rx_serial_8n1
// Asynchronous serial receiver, 8 data bits, no parity, 1 stop bit, LSB first.
// Feeds the game control unit's reception path: each correctly framed byte
// is presented on dado_recebido together with a one-cycle pronto_recepcao
// pulse. A low stop bit raises a one-cycle erro_quadro pulse instead and the
// byte is discarded.
//
// Parameters
//   CLKS_PER_BIT    clock cycles per bit period (even, >= 4)
// Ports
//   clock           system clock, rising edge
//   reset           asynchronous reset, active low
//   zera            synchronous clear: abort frame, clear dado_recebido
//   rx              serial line, idle high, asynchronous to clock
//   dado_recebido   last correctly framed byte
//   pronto_recepcao one-cycle pulse, dado_recebido just updated
//   erro_quadro     one-cycle pulse, stop bit sampled low
//   db_estado       current state code (1111 for an illegal code)
// ---------------------------------------------------------------------------
module rx_serial_8n1 #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zera,
  input  logic       rx,
  output logic [7:0] dado_recebido,
  output logic       pronto_recepcao,
  output logic       erro_quadro,
  output logic [3:0] db_estado
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [3:0] {
    OCIOSO      = 4'b0000,
    INICIO      = 4'b0001,
    DADOS       = 4'b0010,
    PARADA      = 4'b0011,
    ENTREGA     = 4'b0100,
    ESPERA_ALTO = 4'b0101
  } state_t;

  // Two-flop synchroniser; both flops reset to the idle line level so a
  // reset never looks like a start edge.
  logic sync1_q;
  logic rx_s_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    dado_q, dado_d;
  logic          pronto_q, pronto_d;
  logic          erro_q, erro_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= OCIOSO;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      dado_q   <= '0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      dado_q   <= dado_d;
      pronto_q <= pronto_d;
      erro_q   <= erro_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    dado_d   = dado_q;
    pronto_d = 1'b0;
    erro_d   = 1'b0;

    case (state_q)
      OCIOSO: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = INICIO;
      end
      INICIO: begin
        // Mid-start-bit check: a line that is high again was only a glitch.
        if (cnt_q == CNT_HALF) begin
          if (rx_s_q) begin
            state_d = OCIOSO;
          end else begin
            state_d = DADOS;
            idx_d   = '0;
          end
        end
      end
      DADOS: begin
        if (cnt_q == CNT_FULL) begin
          // Explicit wrap: CLKS_PER_BIT is generally not a power of two.
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PARADA;
        end
      end
      PARADA: begin
        if (cnt_q == CNT_FULL) begin
          if (rx_s_q) begin
            // The byte and its pulse are registered on the way into
            // ENTREGA so both are visible in the same (ENTREGA) cycle.
            state_d  = ENTREGA;
            dado_d   = shift_q;
            pronto_d = 1'b1;
          end else begin
            state_d = ESPERA_ALTO;
            erro_d  = 1'b1;
          end
        end
      end
      ENTREGA: begin
        state_d = OCIOSO;
      end
      ESPERA_ALTO: begin
        // A break or stuck-low line must go high before a new start edge
        // can be recognised.
        cnt_d = '0;
        if (rx_s_q) state_d = OCIOSO;
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Clear has priority over every event of the same cycle.
    if (zera) begin
      state_d  = OCIOSO;
      cnt_d    = '0;
      idx_d    = '0;
      dado_d   = '0;
      pronto_d = 1'b0;
      erro_d   = 1'b0;
    end
  end

  always_comb begin
    case (state_q)
      OCIOSO, INICIO, DADOS, PARADA, ENTREGA, ESPERA_ALTO: db_estado = state_q;
      default:                                             db_estado = 4'b1111;
    endcase
  end

  assign dado_recebido   = dado_q;
  assign pronto_recepcao = pronto_q;
  assign erro_quadro     = erro_q;

endmodule

// File: tb/tb_rx_serial_8n1.sv
// ---------------------------------------------------------------------------
// tb_rx_serial_8n1
// Directed scenarios plus a randomized frame stream for rx_serial_8n1 with
// CLKS_PER_BIT = 16. Expected deliveries come from a frame-level model:
// a frame with a high stop bit delivers its byte, a low stop bit produces
// one framing error and no delivery; glitches, resets and clears deliver
// nothing.
// ---------------------------------------------------------------------------
module tb_rx_serial_8n1;

  localparam int CPB = 16;

  logic       clock;
  logic       reset;
  logic       zera;
  logic       rx;
  logic [7:0] dado_recebido;
  logic       pronto_recepcao;
  logic       erro_quadro;
  logic [3:0] db_estado;

  rx_serial_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clock           (clock),
    .reset           (reset),
    .zera            (zera),
    .rx              (rx),
    .dado_recebido   (dado_recebido),
    .pronto_recepcao (pronto_recepcao),
    .erro_quadro     (erro_quadro),
    .db_estado       (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed behaviour
  logic [7:0] got_q[$];
  logic [3:0] state_log[$];
  int         err_seen = 0;
  int         viol     = 0;
  logic       prev_p   = 1'b0;
  logic       prev_e   = 1'b0;
  logic [3:0] last_db  = 4'd0;

  // Reference model state
  logic [7:0] exp_q[$];
  int         exp_err   = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  // Monitor samples 2 time units after the rising edge.
  always @(posedge clock) begin
    #2;
    if (reset) begin
      if (pronto_recepcao) got_q.push_back(dado_recebido);
      if (erro_quadro) err_seen++;
      if (pronto_recepcao && erro_quadro) viol++;
      if ((pronto_recepcao && prev_p) || (erro_quadro && prev_e)) viol++;
      if (db_estado != last_db) state_log.push_back(db_estado);
    end
    last_db = db_estado;
    prev_p  = pronto_recepcao;
    prev_e  = erro_quadro;
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    $display("tx byte=0x%02h stop=%0b", b, stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back(b);
      last_good = b;
    end else begin
      exp_err++;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic check_deliveries(input string tag);
    int n;
    check({tag, "_npulse"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_data"}, got_q[i], exp_q[i]);
    check({tag, "_nerr"}, err_seen, exp_err);
    got_q.delete();
    exp_q.delete();
    err_seen = 0;
    exp_err  = 0;
  endtask

  initial begin
    logic [3:0]  seq_exp [5];
    logic [7:0]  b;
    logic        good;

    reset = 1'b0;
    zera  = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_dado",   dado_recebido,   8'h00);
    check("rst_pronto", pronto_recepcao, 1'b0);
    check("rst_erro",   erro_quadro,     1'b0);
    check("rst_estado", db_estado,       4'h0);
    reset = 1'b1;
    idle(4);
    check("post_rst_estado", db_estado, 4'h0);

    // Single good frame with state sequence
    state_log.delete();
    send_frame(8'hA5, 1'b1); model_frame(8'hA5, 1'b1);
    idle(2 * CPB);
    check_deliveries("single");
    check("single_dado", dado_recebido, last_good);
    seq_exp = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0};
    check("seq_len", state_log.size(), 5);
    for (int i = 0; i < 5 && i < state_log.size(); i++)
      check("seq_state", state_log[i], seq_exp[i]);

    // Back-to-back frames, no idle gap
    send_frame(8'h01, 1'b1); model_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1); model_frame(8'h80, 1'b1);
    send_frame(8'hFF, 1'b1); model_frame(8'hFF, 1'b1);
    idle(2 * CPB);
    check_deliveries("b2b");

    // Start glitch
    $display("tx glitch 4 cycles");
    rx = 1'b0;
    repeat (4) @(negedge clock);
    idle(2 * CPB);
    check_deliveries("glitch");
    check("glitch_estado", db_estado, 4'h0);
    check("glitch_dado", dado_recebido, last_good);

    // Framing error followed by a held-low line, then a good frame
    send_frame(8'h3C, 1'b0); model_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (20) @(negedge clock);
    check("brk_estado", db_estado, 4'h5);
    repeat (20) @(negedge clock);
    check("brk_estado_late", db_estado, 4'h5);
    check("brk_dado", dado_recebido, last_good);
    idle(8);
    check("brk_release", db_estado, 4'h0);
    send_frame(8'h5A, 1'b1); model_frame(8'h5A, 1'b1);
    idle(2 * CPB);
    check_deliveries("framing");
    check("framing_dado", dado_recebido, last_good);

    // Reset during bit 4 of 0xC3; the transmitter is cut off with it
    $display("tx byte=0xc3 cut by reset in bit 4");
    b = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rx = b[4];
    repeat (CPB / 2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("midrst_dado",   dado_recebido,   8'h00);
    check("midrst_estado", db_estado,       4'h0);
    check("midrst_pronto", pronto_recepcao, 1'b0);
    check("midrst_erro",   erro_quadro,     1'b0);
    last_good = 8'h00;
    rx    = 1'b1;
    reset = 1'b1;
    idle(3 * CPB);
    send_frame(8'h66, 1'b1); model_frame(8'h66, 1'b1);
    idle(2 * CPB);
    check_deliveries("midrst");
    check("midrst_next_dado", dado_recebido, last_good);

    // zera held across the stop-bit sample of 0xC3
    $display("tx byte=0xc3 cleared at stop sample");
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    rx = 1'b1;
    repeat (8) @(negedge clock);
    zera = 1'b1;
    repeat (4) @(negedge clock);
    zera = 1'b0;
    repeat (CPB - 12) @(negedge clock);
    last_good = 8'h00;
    idle(2 * CPB);
    check_deliveries("zera");
    check("zera_dado", dado_recebido, 8'h00);
    check("zera_estado", db_estado, 4'h0);

    // Randomized frame stream
    for (int f = 0; f < 16; f++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      send_frame(b, good);
      model_frame(b, good);
      if (!good) begin
        rx = 1'b0;
        repeat ($urandom_range(0, 30)) @(negedge clock);
        idle(4);
      end
      idle($urandom_range(0, 12));
    end
    idle(2 * CPB);
    check_deliveries("rand");
    check("rand_dado", dado_recebido, last_good);

    check("pulse_rules", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
